// File: rtl/dac_slew_out.sv
// DAC output stage: optional polarity inversion, slew-rate limited ramping
// between zero and the incoming sample, and offset-binary conversion for the DAC pins.
module dac_slew_out #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             dac_clk_i,
   input  logic             dac_rst_i,
   input  logic [13:0]      dat_i,
   input  logic             en_i,
   input  logic             set_inv_i,
   input  logic [13:0]      set_step_i,
   input  logic [DIV_W-1:0] set_div_i,
   output logic [13:0]      dac_dat_o,
   output logic [13:0]      dac_val_o,
   output logic [1:0]       state_o,
   output logic             busy_o
);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_RISE  = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;
   localparam logic [1:0] ST_FALL  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [13:0]      dat_r_q, dat_r_d;
   logic [13:0]      y_q, y_d;
   logic [13:0]      dac_q, dac_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;

   logic [13:0] tgt;
   logic        tick;
   logic [14:0] diff, mag, step_w, sum_up, sum_dn;

   // -8192 has no positive counterpart in 14 bits, so its negation clips to +8191
   always_comb begin
      dat_r_d = dat_i;
      if (set_inv_i) begin
         if (dat_i == 14'h2000) dat_r_d = 14'h1FFF;
         else                   dat_r_d = ~dat_i + 14'd1;
      end
   end

   assign tgt  = ((state_q == ST_RISE) || (state_q == ST_TRACK)) ? dat_r_q : '0;
   assign tick = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
      if (tick) cnt_d = set_div_i;
   end

   // Moving by a full step only when |tgt - y| > step keeps y between its
   // old value and tgt, which bounds it to the 14-bit range without clamping
   always_comb begin
      step_w = {1'b0, set_step_i};
      diff   = {tgt[13], tgt} - {y_q[13], y_q};
      mag    = diff[14] ? (~diff + 15'd1) : diff;
      sum_up = {y_q[13], y_q} + step_w;
      sum_dn = {y_q[13], y_q} - step_w;
      y_d    = y_q;
      if (set_step_i == '0) begin
         y_d = tgt;
      end else if (tick) begin
         if (mag <= step_w)  y_d = tgt;
         else if (!diff[14]) y_d = sum_up[13:0];
         else                y_d = sum_dn[13:0];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF: begin
            if (en_i) state_d = ST_RISE;
         end
         ST_RISE: begin
            if (!en_i)          state_d = ST_FALL;
            else if (y_q == tgt) state_d = ST_TRACK;
         end
         ST_TRACK: begin
            if (!en_i) state_d = ST_FALL;
         end
         default: begin
            if (en_i)            state_d = ST_RISE;
            else if (y_q == '0)  state_d = ST_OFF;
         end
      endcase
   end

   assign dac_d = {~y_q[13], y_q[12:0]};

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state_q <= ST_OFF;
         dat_r_q <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         dac_q   <= 14'h2000;
      end else begin
         state_q <= state_d;
         dat_r_q <= dat_r_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         dac_q   <= dac_d;
      end
   end

   assign dac_dat_o = dac_q;
   assign dac_val_o = y_q;
   assign state_o   = state_q;
   assign busy_o    = (y_q != tgt);

endmodule

// File: tb/tb_dac_slew_out.sv
// Randomized and directed checks of dac_slew_out against an integer reference model.
module tb_dac_slew_out;

   logic        clk;
   logic        rst;
   logic [13:0] dat_w, step_w;
   logic [15:0] div_w;
   logic        en, inv;
   logic [13:0] dac_dat_o, dac_val_o;
   logic [1:0]  state_o;
   logic        busy_o;

   int dat, step, div;
   int ntests, nfail;
   int m_st, m_y, m_datr, m_cnt, m_dac;

   assign dat_w  = dat[13:0];
   assign step_w = step[13:0];
   assign div_w  = div[15:0];

   dac_slew_out #(.DIV_W(16)) dut (
      .dac_clk_i (clk),
      .dac_rst_i (rst),
      .dat_i     (dat_w),
      .en_i      (en),
      .set_inv_i (inv),
      .set_step_i(step_w),
      .set_div_i (div_w),
      .dac_dat_o (dac_dat_o),
      .dac_val_o (dac_val_o),
      .state_o   (state_o),
      .busy_o    (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      ntests++;
      if (obs !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_y = 0; m_datr = 0; m_cnt = 0; m_dac = 8192;
   endtask

   // One clock edge of behaviour, from the pre-edge inputs and model state
   task automatic model_step();
      int tgt, ny, nst, d;
      bit tick;
      if (rst) begin
         model_reset();
         return;
      end
      tgt  = (m_st == 1 || m_st == 2) ? m_datr : 0;
      tick = (m_cnt == 0);
      if (step == 0) ny = tgt;
      else if (tick) begin
         d = tgt - m_y;
         if (d >= -step && d <= step) ny = tgt;
         else if (d > 0)              ny = m_y + step;
         else                         ny = m_y - step;
      end else ny = m_y;
      case (m_st)
         0:       nst = en ? 1 : 0;
         1:       nst = !en ? 3 : ((m_y == tgt) ? 2 : 1);
         2:       nst = en ? 2 : 3;
         default: nst = en ? 1 : ((m_y == 0) ? 0 : 3);
      endcase
      m_dac  = m_y + 8192;
      m_cnt  = tick ? div : m_cnt - 1;
      m_datr = inv ? ((dat == -8192) ? 8191 : -dat) : dat;
      m_y    = ny;
      m_st   = nst;
   endtask

   task automatic check_all();
      int tgt;
      tgt = (m_st == 1 || m_st == 2) ? m_datr : 0;
      chk("dac",   int'(dac_dat_o), m_dac);
      chk("val",   int'($signed(dac_val_o)), m_y);
      chk("state", int'(state_o), m_st);
      chk("busy",  int'(busy_o), (m_y != tgt) ? 1 : 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      ntests = 0; nfail = 0;
      rst = 1'b0; en = 1'b0; inv = 1'b0; dat = 0; step = 0; div = 0;
      model_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_dac",   int'(dac_dat_o), 16'h2000);
      chk("rst_val",   int'(dac_val_o), 0);
      chk("rst_state", int'(state_o), 0);
      chk("rst_busy",  int'(busy_o), 0);
      cyc(); cyc();
      rst = 1'b0;

      // bypass latency
      step = 0; en = 1'b1; dat = 16'h1000;
      cyc(); cyc();
      chk("byp_early", int'(dac_dat_o), 16'h2000);
      cyc();
      chk("byp_dac", int'(dac_dat_o), 16'h3000);
      cyc();
      chk("byp_state", int'(state_o), 2);
      chk("byp_busy", int'(busy_o), 0);

      // rise with step 100 every cycle
      do_reset();
      step = 100; div = 0; dat = 1000; en = 1'b0;
      cyc(); cyc();
      en = 1'b1;
      for (int i = 0; i < 14; i++) cyc();
      chk("rise_y", int'($signed(dac_val_o)), 1000);
      chk("rise_state", int'(state_o), 2);
      chk("rise_busy", int'(busy_o), 0);

      // fall with step 250 every 4 cycles
      step = 250; div = 3; en = 1'b0;
      for (int i = 0; i < 24; i++) cyc();
      chk("fall_state", int'(state_o), 0);
      chk("fall_dac", int'(dac_dat_o), 16'h2000);

      // inversion saturation
      inv = 1'b1; step = 0; dat = -8192; en = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      chk("inv_y", int'($signed(dac_val_o)), 8191);
      chk("inv_dac", int'(dac_dat_o), 16'h3FFF);

      // re-enable mid-fall
      inv = 1'b0; dat = 1000; step = 100; div = 0;
      for (int i = 0; i < 200 && !(m_st == 2 && m_y == 1000); i++) cyc();
      chk("pre_track", int'(state_o), 2);
      en = 1'b0;
      for (int i = 0; i < 20 && m_y != 500; i++) cyc();
      chk("fall_500", int'($signed(dac_val_o)), 500);
      en = 1'b1; dat = 800;
      cyc();
      chk("reen_rise", int'(state_o), 1);
      for (int i = 0; i < 20 && m_st != 2; i++) cyc();
      chk("reen_track", int'(state_o), 2);
      chk("reen_y", int'($signed(dac_val_o)), 800);

      // asynchronous reset mid-ramp
      do_reset();
      step = 100; div = 0; dat = 1000; en = 1'b1;
      for (int i = 0; i < 20 && m_y != 300; i++) cyc();
      chk("mid_y300", int'($signed(dac_val_o)), 300);
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_y", int'(dac_val_o), 0);
      chk("arst_dac", int'(dac_dat_o), 16'h2000);
      chk("arst_state", int'(state_o), 0);
      cyc();
      rst = 1'b0;

      // randomized operation
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(15) == 0) en = ~en;
         if ($urandom_range(7) == 0)  dat = int'($urandom_range(16383)) - 8192;
         if ($urandom_range(60) == 0) inv = ~inv;
         if ($urandom_range(40) == 0) step = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(1, 3000));
         if ($urandom_range(40) == 0) div = int'($urandom_range(3));
         if ($urandom_range(400) == 0) do_reset();
         else cyc();
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
